keypad_scanner: RTL and testbench

4x4 hex keypad scanner for the user-interface board, the input-side counterpart of the seven-segment display driver. It drives one keypad column low at a time and samples the row lines through a synchronizer. Each press is debounced over whole scan frames and delivered as a single hex-digit event on a valid/ready handshake. It also shifts the digit into a 32-bit entry register that feeds the display's 32-bit data input directly.

---
 rtl/user_interface_pkg.sv | 40 ++++
 rtl/key_debounce_fsm.sv | 91 +++++++++
 rtl/keypad_scanner.sv | 125 ++++++++++++
 tb/tb_keypad_scanner.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/user_interface_pkg.sv
// Shared definitions for the user-interface board: keypad debounce states,
// frame-result encoding and small row-decoding helpers.
package user_interface_pkg;

    localparam int KEY_W = 4;

    typedef logic [1:0] deb_state_t;
    localparam deb_state_t IDLE      = 2'd0;
    localparam deb_state_t PRESS_DEB = 2'd1;
    localparam deb_state_t HELD      = 2'd2;
    localparam deb_state_t REL_DEB   = 2'd3;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } frame_kind_t;

    // Pressed rows read low; anything above one key is a ghost, so saturate at 2.
    function automatic logic [1:0] low_count(input logic [3:0] rows);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, ~rows[i]};
        end
        return (n > 3'd1) ? 2'd2 : n[1:0];
    endfunction

    function automatic logic [1:0] first_low(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_debounce_fsm.sv
// Frame-level debounce: turns a stream of per-frame scan results into single
// press events, with matching release filtering and no auto-repeat.
module key_debounce_fsm
    import user_interface_pkg::*;
#(
    parameter logic [2:0] DEBOUNCE_SCANS = 3'd4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             frame_valid,
    input  frame_kind_t      frame_kind,
    input  logic [KEY_W-1:0] frame_code,
    output logic             emit,
    output logic [KEY_W-1:0] emit_code
);

    deb_state_t       state, state_nxt;
    logic [2:0]       cnt, cnt_nxt, cnt_inc;
    logic [KEY_W-1:0] cand, cand_nxt;
    logic             is_key;

    // MULTI frames are deliberately folded into NONE.
    assign is_key    = (frame_kind == SINGLE);
    assign cnt_inc   = cnt + 3'd1;
    assign emit_code = frame_code;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cand_nxt  = cand;
        emit      = 1'b0;
        if (frame_valid) begin
            case (state)
                IDLE: begin
                    if (is_key) begin
                        cand_nxt = frame_code;
                        cnt_nxt  = 3'd1;
                        if (DEBOUNCE_SCANS == 3'd1) begin
                            emit      = 1'b1;
                            state_nxt = HELD;
                        end else begin
                            state_nxt = PRESS_DEB;
                        end
                    end
                end
                PRESS_DEB: begin
                    if (!is_key) begin
                        state_nxt = IDLE;
                    end else if (frame_code != cand) begin
                        cand_nxt = frame_code;
                        cnt_nxt  = 3'd1;
                    end else if (cnt_inc == DEBOUNCE_SCANS) begin
                        emit      = 1'b1;
                        state_nxt = HELD;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                HELD: begin
                    if (!is_key) begin
                        cnt_nxt   = 3'd1;
                        state_nxt = (DEBOUNCE_SCANS == 3'd1) ? IDLE : REL_DEB;
                    end
                end
                REL_DEB: begin
                    if (is_key) begin
                        state_nxt = HELD;
                    end else if (cnt_inc == DEBOUNCE_SCANS) begin
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
            cand  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            cand  <= cand_nxt;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: column strobing, row synchronisation, frame collection,
// debounced key events on a valid/ready handshake and an 8-digit entry register.
module keypad_scanner
    import user_interface_pkg::*;
#(
    parameter logic [15:0] SCAN_INTERVAL  = 16'd49999,
    parameter logic [2:0]  DEBOUNCE_SCANS = 3'd4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [3:0]       i_row,
    input  logic             i_key_ready,
    input  logic             i_clear,
    output logic [3:0]       o_col,
    output logic             o_key_valid,
    output logic [KEY_W-1:0] o_key_code,
    output logic [31:0]      o_entry,
    output logic             o_overrun
);

    logic [3:0]       row_meta, row_sync;
    logic [15:0]      dwell;
    logic [1:0]       col_idx;
    logic             sample;
    logic [1:0]       acc_cnt, base_cnt, merged_cnt;
    logic [KEY_W-1:0] acc_code, merged_code;
    logic [2:0]       sum;
    logic             frame_valid;
    frame_kind_t      frame_kind;
    logic             emit;
    logic [KEY_W-1:0] emit_code;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            row_meta <= 4'd0;
            row_sync <= 4'd0;
        end else begin
            row_meta <= i_row;
            row_sync <= row_meta;
        end
    end

    assign sample = (dwell == SCAN_INTERVAL);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dwell   <= 16'd0;
            col_idx <= 2'd0;
        end else if (sample) begin
            dwell   <= 16'd0;
            col_idx <= col_idx + 2'd1;
        end else begin
            dwell <= dwell + 16'd1;
        end
    end

    assign o_col = ~(4'b0001 << col_idx);

    // Column 0 opens a new frame, so the tally carried from the last frame is dropped.
    assign base_cnt    = (col_idx == 2'd0) ? 2'd0 : acc_cnt;
    assign sum         = {1'b0, base_cnt} + {1'b0, low_count(row_sync)};
    assign merged_cnt  = (sum > 3'd1) ? 2'd2 : sum[1:0];
    assign merged_code = (base_cnt == 2'd0) ? {first_low(row_sync), col_idx} : acc_code;
    assign frame_valid = sample && (col_idx == 2'd3);

    always_comb begin
        case (merged_cnt)
            2'd0:    frame_kind = NONE;
            2'd1:    frame_kind = SINGLE;
            default: frame_kind = MULTI;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_cnt  <= 2'd0;
            acc_code <= '0;
        end else if (sample) begin
            acc_cnt  <= merged_cnt;
            acc_code <= merged_code;
        end
    end

    key_debounce_fsm #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .frame_valid(frame_valid),
        .frame_kind (frame_kind),
        .frame_code (merged_code),
        .emit       (emit),
        .emit_code  (emit_code)
    );

    // A ready consumer retires the old event in the same cycle a new one loads.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_key_valid <= 1'b0;
            o_key_code  <= '0;
            o_overrun   <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (emit) begin
                if (!o_key_valid || i_key_ready) begin
                    o_key_valid <= 1'b1;
                    o_key_code  <= emit_code;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_key_valid && i_key_ready) begin
                o_key_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            o_entry <= 32'd0;
        end else if (emit) begin
            o_entry <= {o_entry[27:0], emit_code};
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed vector table for the key scenarios, then
// randomized key patterns checked against a frame-level behavioural model.
module tb_keypad_scanner;

    localparam logic [15:0] SI    = 16'd3;
    localparam logic [2:0]  DS    = 3'd2;
    localparam int          FRAME = 16;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [3:0]  i_row;
    logic        i_key_ready;
    logic        i_clear;
    logic [3:0]  o_col;
    logic        o_key_valid;
    logic [3:0]  o_key_code;
    logic [31:0] o_entry;
    logic        o_overrun;
    logic [15:0] pressed;

    int n_checks;
    int n_fail;

    typedef struct {
        logic        rst;
        logic [15:0] mask;
        logic        ready;
        logic        clr;
        int          reps;
        logic        valid;
        logic [3:0]  code;
        logic [31:0] entry;
        logic        ov;
    } vec_t;

    vec_t vecs[$];

    // Frame-level reference state
    int          m_prev, m_streak, m_none;
    bit          m_down;
    logic        m_valid, m_ov;
    logic [3:0]  m_code;
    logic [31:0] m_entry;

    always #5 clk = ~clk;

    // Passive keypad: a row reads low when a pressed key sits on a driven-low column.
    function automatic logic [3:0] keypad_rows(input logic [3:0] col, input logic [15:0] keys);
        logic [3:0] rows;
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!col[c] && keys[r*4+c]) rows[r] = 1'b0;
        return rows;
    endfunction

    assign i_row = keypad_rows(o_col, pressed);

    keypad_scanner #(
        .SCAN_INTERVAL (SI),
        .DEBOUNCE_SCANS(DS)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_row      (i_row),
        .i_key_ready(i_key_ready),
        .i_clear    (i_clear),
        .o_col      (o_col),
        .o_key_valid(o_key_valid),
        .o_key_code (o_key_code),
        .o_entry    (o_entry),
        .o_overrun  (o_overrun)
    );

    function automatic vec_t mk(input logic rst, input logic [15:0] mask, input logic ready,
                                input logic clr, input int reps, input logic v,
                                input logic [3:0] c, input logic [31:0] e, input logic ov);
        vec_t t;
        t.rst = rst; t.mask = mask; t.ready = ready; t.clr = clr; t.reps = reps;
        t.valid = v; t.code = c; t.entry = e; t.ov = ov;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkFrame(input string tag, input logic v, input logic [3:0] c,
                              input logic [31:0] e, input logic ov);
        checkOutput({tag, " o_key_valid"}, 32'(o_key_valid), 32'(v));
        checkOutput({tag, " o_key_code"}, 32'(o_key_code), 32'(c));
        checkOutput({tag, " o_entry"}, o_entry, e);
        checkOutput({tag, " o_overrun"}, 32'(o_overrun), 32'(ov));
    endtask

    // Leaves the bench at the negedge of cycle 0 of the first frame.
    task automatic doReset();
        pressed     = 16'd0;
        i_key_ready = 1'b0;
        i_clear     = 1'b0;
        i_rst       = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        i_rst = 1'b0;
    endtask

    // Each rep is one full frame; clear is raised only in the emit cycle of the last rep.
    task automatic applyStimulus(input logic [15:0] mask, input logic ready, input logic clr, input int reps);
        for (int f = 0; f < reps; f++) begin
            pressed     = mask;
            i_key_ready = ready;
            i_clear     = 1'b0;
            repeat (FRAME - 1) @(posedge clk);
            @(negedge clk);
            i_clear = clr && (f == reps - 1);
            @(posedge clk);
            @(negedge clk);
            i_clear = 1'b0;
        end
    endtask

    task automatic modelReset();
        m_prev = -1; m_streak = 0; m_none = 0; m_down = 0;
        m_valid = 1'b0; m_ov = 1'b0; m_code = 4'd0; m_entry = 32'd0;
    endtask

    // A press is a run of DS identical single-key frames; a release is a run of DS empty frames.
    task automatic modelFrame(input logic [15:0] mask, input logic ready, input logic clr);
        int res;
        bit ev;
        res = -1;
        if ($countones(mask) == 1)
            for (int k = 0; k < 16; k++) if (mask[k]) res = k;
        if (res == m_prev) m_streak++;
        else begin m_streak = 1; m_prev = res; end
        ev = 0;
        if (!m_down) begin
            if (res >= 0 && m_streak == int'(DS)) begin ev = 1; m_down = 1; m_none = 0; end
        end else begin
            m_none = (res < 0) ? m_none + 1 : 0;
            if (m_none == int'(DS)) m_down = 0;
        end
        if (ready) m_valid = 1'b0;
        m_ov = 1'b0;
        if (ev) begin
            if (!m_valid) begin m_valid = 1'b1; m_code = res[3:0]; end
            else m_ov = 1'b1;
        end
        if (clr) m_entry = 32'd0;
        else if (ev) m_entry = {m_entry[27:0], res[3:0]};
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        logic [31:0] e_acc;
        logic [15:0] mask;
        logic        rdy, clr;
        int          kind, k1, k2, hold;

        n_checks = 0;
        n_fail   = 0;
        pressed  = 16'd0;
        i_rst    = 1'b1;
        i_key_ready = 1'b0;
        i_clear  = 1'b0;

        $display("[TB] reset values and first column step");
        doReset();
        checkOutput("reset o_col", 32'(o_col), 32'(4'b1110));
        checkFrame("reset", 1'b0, 4'h0, 32'h0, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("o_col after 4 cycles", 32'(o_col), 32'(4'b1101));

        // Clean press, long hold, re-press
        vecs.push_back(mk(1, 16'd1 << 9, 1, 0, 1,  0, 4'h0, 32'h0,    0));
        vecs.push_back(mk(0, 16'd1 << 9, 1, 0, 1,  1, 4'h9, 32'h9,    0));
        vecs.push_back(mk(0, 16'd1 << 9, 1, 0, 10, 0, 4'h9, 32'h9,    0));
        vecs.push_back(mk(0, 16'd0,      1, 0, 2,  0, 4'h9, 32'h9,    0));
        vecs.push_back(mk(0, 16'd1 << 9, 1, 0, 2,  1, 4'h9, 32'h99,   0));
        vecs.push_back(mk(0, 16'd0,      1, 0, 2,  0, 4'h9, 32'h99,   0));
        // Bounce on press, glitches after release
        vecs.push_back(mk(0, 16'd1 << 5, 1, 0, 1,  0, 4'h9, 32'h99,   0));
        vecs.push_back(mk(0, 16'd0,      1, 0, 1,  0, 4'h9, 32'h99,   0));
        vecs.push_back(mk(0, 16'd1 << 5, 1, 0, 2,  1, 4'h5, 32'h995,  0));
        vecs.push_back(mk(0, 16'd1 << 5, 1, 0, 1,  0, 4'h5, 32'h995,  0));
        vecs.push_back(mk(0, 16'd0,      1, 0, 1,  0, 4'h5, 32'h995,  0));
        vecs.push_back(mk(0, 16'd1 << 5, 1, 0, 1,  0, 4'h5, 32'h995,  0));
        vecs.push_back(mk(0, 16'd0,      1, 0, 2,  0, 4'h5, 32'h995,  0));
        vecs.push_back(mk(0, 16'd1 << 5, 1, 0, 1,  0, 4'h5, 32'h995,  0));
        vecs.push_back(mk(0, 16'd0,      1, 0, 2,  0, 4'h5, 32'h995,  0));
        // Ghosting: two keys suppressed, remaining key accepted
        vecs.push_back(mk(0, (16'd1 << 1) | (16'd1 << 6), 1, 0, 5, 0, 4'h5, 32'h995, 0));
        vecs.push_back(mk(0, 16'd1 << 1, 1, 0, 2,  1, 4'h1, 32'h9951, 0));
        vecs.push_back(mk(0, 16'd0,      1, 0, 2,  0, 4'h1, 32'h9951, 0));
        // Overrun with a stalled consumer
        vecs.push_back(mk(1, 16'd1 << 3, 0, 0, 2,  1, 4'h3, 32'h3,    0));
        vecs.push_back(mk(0, 16'd0,      0, 0, 2,  1, 4'h3, 32'h3,    0));
        vecs.push_back(mk(0, 16'd1 << 4, 0, 0, 2,  1, 4'h3, 32'h34,   1));
        // Digits 1..9 wrap the entry register, then clear collides with digit A
        e_acc = 32'd0;
        for (int d = 1; d <= 9; d++) begin
            e_acc = {e_acc[27:0], 4'(d)};
            vecs.push_back(mk(d == 1, 16'd1 << d, 1, 0, 2, 1, 4'(d), e_acc, 0));
            vecs.push_back(mk(0, 16'd0, 1, 0, 2, 0, 4'(d), e_acc, 0));
        end
        vecs.push_back(mk(0, 16'd1 << 10, 1, 1, 2, 1, 4'hA, 32'h0, 0));

        $display("[TB] directed vectors: %0d", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) doReset();
            applyStimulus(vecs[i].mask, vecs[i].ready, vecs[i].clr, vecs[i].reps);
            checkFrame($sformatf("vec%0d", i), vecs[i].valid, vecs[i].code, vecs[i].entry, vecs[i].ov);
            if (vecs[i].ov) begin
                @(posedge clk);
                @(negedge clk);
                checkOutput($sformatf("vec%0d overrun width", i), 32'(o_overrun), 32'd0);
                repeat (FRAME - 1) @(posedge clk);
                @(negedge clk);
            end
        end

        $display("[TB] randomized key patterns");
        doReset();
        modelReset();
        for (int seg = 0; seg < 60; seg++) begin
            kind = $urandom_range(0, 4);
            k1   = $urandom_range(0, 15);
            k2   = (k1 + $urandom_range(1, 15)) % 16;
            if (kind == 0)      mask = 16'd0;
            else if (kind < 4)  mask = 16'd1 << k1;
            else                mask = (16'd1 << k1) | (16'd1 << k2);
            hold = $urandom_range(1, 4);
            for (int h = 0; h < hold; h++) begin
                rdy = ($urandom_range(0, 3) != 0);
                clr = ($urandom_range(0, 7) == 0);
                applyStimulus(mask, rdy, clr, 1);
                modelFrame(mask, rdy, clr);
                checkFrame($sformatf("rand seg%0d f%0d", seg, h), m_valid, m_code, m_entry, m_ov);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
